// File: rtl/xt_hb_master_bridge.sv
// xt_hb_master_bridge
//   Initiator end of XT_HB. Turns single CPU load/store requests into XT_HB
//   slave-domain read/write transactions, one outstanding at a time, and
//   returns a one-cycle completion with read data or error.
//
// Parameters
//   TIMEOUT_CYCLES  cycles an enable may be held awaiting finish (1..32);
//                   only used when XT_HB_TIMEOUT_EN is defined
//
// Configuration macro
//   XT_HB_TIMEOUT_EN  adds a 5-bit wait counter; an access that sees no
//                     finish within TIMEOUT_CYCLES completes with resp_err
//
// Ports
//   hb_clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready             CPU request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata     request kind, byte address, write data
//   resp_valid, resp_err, resp_rdata  completion pulse, error flag, read data
//   hb_raddr, hb_ren                XT_HB read address / enable
//   hb_waddr, hb_wdata, hb_wen      XT_HB write address / data / enable
//   read_finish, write_finish       domain completion strobes
//   hb_rdata                        domain read data (valid with read_finish)
module xt_hb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        hb_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [7:0]  hb_raddr,
    output logic [7:0]  hb_waddr,
    output logic [31:0] hb_wdata,
    output logic        hb_ren,
    output logic        hb_wen,
    input  logic        read_finish,
    input  logic        write_finish,
    input  logic [31:0] hb_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..32 for the 5-bit wait counter");
    end

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic        req_ready_nx, resp_valid_nx, resp_err_nx, hb_ren_nx, hb_wen_nx;
    logic [31:0] resp_rdata_nx, hb_wdata_nx;
    logic [7:0]  hb_raddr_nx, hb_waddr_nx;
`ifdef XT_HB_TIMEOUT_EN
    logic [4:0]  wait_cnt, wait_cnt_nx;
`endif

    always_comb begin
        state_nx      = state;
        resp_err_nx   = resp_err;
        resp_rdata_nx = resp_rdata;
        hb_raddr_nx   = hb_raddr;
        hb_waddr_nx   = hb_waddr;
        hb_wdata_nx   = hb_wdata;
        hb_ren_nx     = hb_ren;
        hb_wen_nx     = hb_wen;
`ifdef XT_HB_TIMEOUT_EN
        wait_cnt_nx   = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef XT_HB_TIMEOUT_EN
                    wait_cnt_nx = '0;
`endif
                    if (req_addr[1:0] != 2'b00) begin
                        resp_err_nx   = 1'b1;
                        resp_rdata_nx = '0;
                        state_nx      = RESP;
                    end else if (req_we) begin
                        resp_err_nx = 1'b0;
                        hb_waddr_nx = req_addr;
                        hb_wdata_nx = req_wdata;
                        hb_wen_nx   = 1'b1;
                        state_nx    = WRITE;
                    end else begin
                        resp_err_nx = 1'b0;
                        hb_raddr_nx = req_addr;
                        hb_ren_nx   = 1'b1;
                        state_nx    = READ;
                    end
                end
            end
            READ: begin
                // finish takes priority over an expiring counter on the same edge
                if (read_finish) begin
                    resp_rdata_nx = hb_rdata;
                    hb_ren_nx     = 1'b0;
                    state_nx      = RESP;
                end
`ifdef XT_HB_TIMEOUT_EN
                else if (wait_cnt == 5'(TIMEOUT_CYCLES - 1)) begin
                    resp_err_nx   = 1'b1;
                    resp_rdata_nx = '0;
                    hb_ren_nx     = 1'b0;
                    state_nx      = RESP;
                end else begin
                    wait_cnt_nx = wait_cnt + 5'd1;
                end
`endif
            end
            WRITE: begin
                if (write_finish) begin
                    hb_wen_nx = 1'b0;
                    state_nx  = RESP;
                end
`ifdef XT_HB_TIMEOUT_EN
                else if (wait_cnt == 5'(TIMEOUT_CYCLES - 1)) begin
                    resp_err_nx   = 1'b1;
                    resp_rdata_nx = '0;
                    hb_wen_nx     = 1'b0;
                    state_nx      = RESP;
                end else begin
                    wait_cnt_nx = wait_cnt + 5'd1;
                end
`endif
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // handshake outputs are registered copies of the state being entered
        resp_valid_nx = (state_nx == RESP);
        req_ready_nx  = (state_nx == IDLE);
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            hb_raddr   <= '0;
            hb_waddr   <= '0;
            hb_wdata   <= '0;
            hb_ren     <= 1'b0;
            hb_wen     <= 1'b0;
`ifdef XT_HB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            state      <= state_nx;
            req_ready  <= req_ready_nx;
            resp_valid <= resp_valid_nx;
            resp_err   <= resp_err_nx;
            resp_rdata <= resp_rdata_nx;
            hb_raddr   <= hb_raddr_nx;
            hb_waddr   <= hb_waddr_nx;
            hb_wdata   <= hb_wdata_nx;
            hb_ren     <= hb_ren_nx;
            hb_wen     <= hb_wen_nx;
`ifdef XT_HB_TIMEOUT_EN
            wait_cnt   <= wait_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_xt_hb_master_bridge.sv
// tb_xt_hb_master_bridge
//   Self-checking bench for xt_hb_master_bridge. A small XT_HB domain model
//   answers reads (finish one cycle after ren is seen, toggling while ren is
//   held) and ties write_finish high. Expected responses are queued when a
//   request is accepted and compared when resp_valid appears.
module tb_xt_hb_master_bridge;

    logic        hb_clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  hb_raddr, hb_waddr;
    logic [31:0] hb_wdata;
    logic        hb_ren, hb_wen;
    logic        read_finish;
    logic        write_finish;
    logic [31:0] hb_rdata;
    logic        rd_stuck;

    xt_hb_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .hb_clk       (hb_clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .hb_raddr     (hb_raddr),
        .hb_waddr     (hb_waddr),
        .hb_wdata     (hb_wdata),
        .hb_ren       (hb_ren),
        .hb_wen       (hb_wen),
        .read_finish  (read_finish),
        .write_finish (write_finish),
        .hb_rdata     (hb_rdata)
    );

    always #5 hb_clk = ~hb_clk;

    function automatic logic [31:0] rd_model(input logic [7:0] a);
        return (a == 8'h14) ? 32'h1234_5678 : {24'hC0FFEE, a};
    endfunction

    // domain model
    assign write_finish = 1'b1;
    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) read_finish <= 1'b0;
        else        read_finish <= !rd_stuck && hb_ren && !read_finish;
    end
    always_comb begin
        hb_rdata = '0;
        if (read_finish) hb_rdata = rd_model(hb_raddr);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          ref_c;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    always @(posedge hb_clk) cyc++;

    // response monitor and enable run-length tracking
    int ren_run = 0, wen_run = 0, last_ren_len = 0, last_wen_len = 0;
    int resp_cnt = 0, last_resp_cyc = 0;
    always @(negedge hb_clk) begin
        if (hb_ren) ren_run++;
        else if (ren_run != 0) begin last_ren_len = ren_run; ren_run = 0; end
        if (hb_wen) wen_run++;
        else if (wen_run != 0) begin last_wen_len = wen_run; wen_run = 0; end
        if (hb_ren && hb_wen) chk_eq("ren_wen_excl", 32'd1, 32'd0);
        if (rst_n && resp_valid) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk_eq("resp_err", 32'(resp_err), 32'(e.err));
                chk_eq("resp_rdata", resp_rdata, e.rd);
                chk_eq("resp_latency", 32'(cyc - e.ref_c), 32'(e.lat));
            end
        end
    end

    // called at a negedge; returns at the negedge just after acceptance
    task automatic do_req(input logic we, input logic [7:0] a, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_rd, input int lat,
                          input bit push, input bit keep, output int ref_c);
        exp_t e;
        bit   ok;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        ok = 1'b0;
        ref_c = cyc;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge hb_clk);
        end
        if (!ok) begin
            chk_eq("accept_timeout", 32'd0, 32'd1);
        end else begin
            ref_c = cyc;
            e.err = exp_err; e.rd = exp_rd; e.lat = lat; e.ref_c = ref_c;
            if (push) exp_q.push_back(e);
        end
        @(negedge hb_clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge hb_clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk_eq({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk_eq({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk_eq({tag, "_hb_raddr"}, 32'(hb_raddr), 32'd0);
        chk_eq({tag, "_hb_waddr"}, 32'(hb_waddr), 32'd0);
        chk_eq({tag, "_hb_wdata"}, hb_wdata, 32'd0);
        chk_eq({tag, "_hb_ren"}, 32'(hb_ren), 32'd0);
        chk_eq({tag, "_hb_wen"}, 32'(hb_wen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r1, r2, rc;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rd_stuck = 1'b0;
        idle(3);
        chk_reset_state("reset");
        rst_n = 1'b1;
        idle(2);

        // aligned read
        do_req(1'b0, 8'h14, 32'h0, 1'b0, 32'h1234_5678, 3, 1'b1, 1'b0, rc);
        chk_eq("rd_ren", 32'(hb_ren), 32'd1);
        chk_eq("rd_raddr", 32'(hb_raddr), 32'h14);
        idle(5);
        chk_eq("rd_ren_len", 32'(last_ren_len), 32'd2);

        // aligned write; resp_rdata keeps the last read value
        do_req(1'b1, 8'h24, 32'hA5A5_0001, 1'b0, 32'h1234_5678, 2, 1'b1, 1'b0, rc);
        chk_eq("wr_wen", 32'(hb_wen), 32'd1);
        chk_eq("wr_waddr", 32'(hb_waddr), 32'h24);
        chk_eq("wr_wdata", hb_wdata, 32'hA5A5_0001);
        idle(5);
        chk_eq("wr_wen_len", 32'(last_wen_len), 32'd1);

        // misaligned read: no bus access
        do_req(1'b0, 8'h15, 32'h0, 1'b1, 32'h0, 1, 1'b1, 1'b0, rc);
        chk_eq("mis_rd_ren", 32'(hb_ren), 32'd0);
        idle(4);

        do_req(1'b0, 8'h20, 32'h0, 1'b0, rd_model(8'h20), 3, 1'b1, 1'b0, rc);
        idle(5);
        do_req(1'b1, 8'h03, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 1'b1, 1'b0, rc);
        chk_eq("mis_wr_wen", 32'(hb_wen), 32'd0);
        idle(4);

        // back-to-back with req_valid held
        do_req(1'b1, 8'h00, 32'h0000_BEEF, 1'b0, 32'h0, 2, 1'b1, 1'b1, r1);
        do_req(1'b0, 8'h00, 32'h0, 1'b0, rd_model(8'h00), 3, 1'b1, 1'b0, r2);
        chk_eq("b2b_gap", 32'(r2 - last_resp_cyc), 32'd1);
        idle(6);
        chk_eq("resp_count", 32'(resp_cnt), 32'd7);

`ifdef XT_HB_TIMEOUT_EN
        rd_stuck = 1'b1;
        do_req(1'b0, 8'h30, 32'h0, 1'b1, 32'h0, 17, 1'b1, 1'b0, rc);
        idle(25);
        chk_eq("to_ren_len", 32'(last_ren_len), 32'd16);
        chk_eq("to_resp_count", 32'(resp_cnt), 32'd8);
`endif

        // stuck read, then reset while hb_ren is high
        rd_stuck = 1'b1;
        r1 = resp_cnt;
        do_req(1'b0, 8'h34, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0, rc);
`ifdef XT_HB_TIMEOUT_EN
        idle(3);
`else
        idle(40);
`endif
        chk_eq("stuck_ren", 32'(hb_ren), 32'd1);
        chk_eq("stuck_no_resp", 32'(resp_cnt), 32'(r1));
        rst_n = 1'b0;
        @(negedge hb_clk);
        chk_reset_state("midrst");
        rst_n = 1'b1;
        rd_stuck = 1'b0;
        idle(5);
        chk_eq("midrst_no_resp", 32'(resp_cnt), 32'(r1));

        // recovery after abort
        do_req(1'b0, 8'h14, 32'h0, 1'b0, 32'h1234_5678, 3, 1'b1, 1'b0, rc);
        idle(6);
        chk_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
